io_strobe_seq: RTL and testbench



---
 rtl/io_seq_pkg.sv | 18 +
 rtl/io_strobe_seq_if.sv | 26 ++
 rtl/io_strobe_seq_phase_cnt.sv | 32 +++
 rtl/io_strobe_seq.sv | 134 +++++++++++++
 tb/tb_io_strobe_seq.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/io_seq_pkg.sv
// Shared definitions for the I/O strobe sequencer: FSM state encoding,
// counter width default and the read/write decode constants.
package io_seq_pkg;

  localparam int CNT_W_DEF = 4;

  localparam logic RD = 1'b0;
  localparam logic WR = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/io_strobe_seq_if.sv
// CPU-request / decoder-drive bundle for the I/O strobe sequencer.
// The host modport is the CPU side; the slave modport is the sequencer.
interface io_strobe_seq_if;

   logic       req;
   logic       we;
   logic [1:0] addr;
   logic       wait_n;
   logic [1:0] A;
   logic [1:0] B;
   logic       G1n;
   logic       G2n;
   logic       busy;
   logic       ack;

   modport master (
      output req, we, addr, wait_n,
      input  A, B, G1n, G2n, busy, ack
   );

   modport slave (
      input  req, we, addr, wait_n,
      output A, B, G1n, G2n, busy, ack
   );

endinterface

// File: rtl/io_strobe_seq_phase_cnt.sv
// Loadable down-counter timing each bus phase; load has priority over
// decrement and the count saturates at zero.
module phase_cnt #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   input  logic             i_dec,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_zero
);

   logic [CNT_W-1:0] r_cnt;

   // NOTE: registers are updated with <= so every always_ff reads the
   // pre-edge value of every other register, independent of block order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_cnt  = r_cnt;
   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/io_strobe_seq.sv
// Bus-cycle sequencer feeding the dual 2-to-4 I/O select decoder: half 1
// carries read strobes, half 2 write strobes. All outputs are registered.
import io_seq_pkg::*;

module io_strobe_seq #(
   parameter int SETUP_CYC  = 2,
   parameter int STROBE_CYC = 3,
   parameter int HOLD_CYC   = 1,
   parameter int CNT_W      = CNT_W_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   io_strobe_seq_if.slave  bus
);

   localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);

   state_e           r_state;
   state_e           w_next;
   logic             r_we;
   logic [1:0]       r_a;
   logic [1:0]       r_b;
   logic             r_g1n;
   logic             r_g2n;
   logic             r_busy;
   logic             r_ack;

   logic             w_load;
   logic [CNT_W-1:0] w_load_val;
   logic             w_dec;
   logic [CNT_W-1:0] w_cnt;
   logic             w_zero;
   logic             w_accept;

   phase_cnt #(
      .CNT_W (CNT_W)
   ) u_phase_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .i_dec      (w_dec),
      .o_cnt      (w_cnt),
      .o_zero     (w_zero)
   );

   // Requests are only honoured from IDLE; anything else is dropped, not queued.
   assign w_accept = (r_state == IDLE) && bus.req;

   // NOTE: every signal assigned here gets a default first, so no path
   // through the case leaves one unassigned and no latch is inferred.
   always_comb begin
      w_next     = r_state;
      w_load     = 1'b0;
      w_load_val = '0;
      w_dec      = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.req) begin
               w_next     = SETUP;
               w_load     = 1'b1;
               w_load_val = SETUP_LD;
            end
         end
         SETUP: begin
            if (w_zero) begin
               w_next     = STROBE;
               w_load     = 1'b1;
               w_load_val = STROBE_LD;
            end else begin
               w_dec = 1'b1;
            end
         end
         STROBE: begin
            // wait_n only matters once the minimum strobe width has elapsed.
            if (w_zero && bus.wait_n) begin
               w_next     = HOLD;
               w_load     = 1'b1;
               w_load_val = HOLD_LD;
            end else begin
               w_dec = 1'b1;
            end
         end
         HOLD: begin
            if (w_zero) begin
               w_next = DONE;
            end else begin
               w_dec = 1'b1;
            end
         end
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with the
   // state they describe, with no input-to-output combinational path.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_we    <= RD;
         r_a     <= 2'd0;
         r_b     <= 2'd0;
         r_g1n   <= 1'b1;
         r_g2n   <= 1'b1;
         r_busy  <= 1'b0;
         r_ack   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_we <= bus.we;
            if (bus.we == RD) begin
               r_a <= bus.addr;
            end else begin
               r_b <= bus.addr;
            end
         end
         r_g1n  <= !((w_next == STROBE) && (r_we == RD));
         r_g2n  <= !((w_next == STROBE) && (r_we == WR));
         r_busy <= (w_next != IDLE);
         r_ack  <= (w_next == DONE);
      end
   end

   assign bus.A    = r_a;
   assign bus.B    = r_b;
   assign bus.G1n  = r_g1n;
   assign bus.G2n  = r_g2n;
   assign bus.busy = r_busy;
   assign bus.ack  = r_ack;

endmodule

// File: tb/tb_io_strobe_seq.sv
// Directed bench for io_strobe_seq: default-timing instance plus a
// minimum-timing instance, with cycle-by-cycle hand-computed expectations.
module tb_io_strobe_seq;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   io_strobe_seq_if u_if ();
   io_strobe_seq_if u_if_min ();

   io_strobe_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if)
   );

   io_strobe_seq #(
      .SETUP_CYC  (1),
      .STROBE_CYC (1),
      .HOLD_CYC   (1)
   ) dut_min (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if_min)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // The two enables of one decoder must never be low together.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         check("excl_def", {31'd0, (u_if.G1n === 1'b0) && (u_if.G2n === 1'b0)}, 32'd0);
         check("excl_min", {31'd0, (u_if_min.G1n === 1'b0) && (u_if_min.G2n === 1'b0)}, 32'd0);
      end
   end

   initial begin
      int acks;
      int busy_seen;
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      u_if.req = 1'b0;     u_if.we = 1'b0;     u_if.addr = 2'd0;     u_if.wait_n = 1'b1;
      u_if_min.req = 1'b0; u_if_min.we = 1'b0; u_if_min.addr = 2'd0; u_if_min.wait_n = 1'b1;

      // Reset state
      tick();
      tick();
      check("rst_A",    u_if.A, 0);
      check("rst_B",    u_if.B, 0);
      check("rst_G1n",  u_if.G1n, 1);
      check("rst_G2n",  u_if.G2n, 1);
      check("rst_busy", u_if.busy, 0);
      check("rst_ack",  u_if.ack, 0);
      rst_n = 1'b1;
      tick();

      // Read cycle, addr 2, no wait states: ack at cycle 7
      u_if.req = 1'b1; u_if.we = 1'b0; u_if.addr = 2'd2;
      tick();
      u_if.req = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         check($sformatf("rd_A_c%0d", c),    u_if.A, 2);
         check($sformatf("rd_B_c%0d", c),    u_if.B, 0);
         check($sformatf("rd_G1n_c%0d", c),  u_if.G1n, (c >= 3 && c <= 5) ? 0 : 1);
         check($sformatf("rd_G2n_c%0d", c),  u_if.G2n, 1);
         check($sformatf("rd_ack_c%0d", c),  u_if.ack, (c == 7) ? 1 : 0);
         check($sformatf("rd_busy_c%0d", c), u_if.busy, (c >= 1 && c <= 7) ? 1 : 0);
         tick();
      end

      // Write cycle, addr 1, wait_n low cycles 5..8: strobe 3..9, ack at 11
      u_if.req = 1'b1; u_if.we = 1'b1; u_if.addr = 2'd1;
      tick();
      u_if.req = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         u_if.wait_n = (c >= 5 && c <= 8) ? 1'b0 : 1'b1;
         check($sformatf("wr_B_c%0d", c),   u_if.B, 1);
         check($sformatf("wr_A_c%0d", c),   u_if.A, 2);
         check($sformatf("wr_G2n_c%0d", c), u_if.G2n, (c >= 3 && c <= 9) ? 0 : 1);
         check($sformatf("wr_G1n_c%0d", c), u_if.G1n, 1);
         check($sformatf("wr_ack_c%0d", c), u_if.ack, (c == 11) ? 1 : 0);
         tick();
      end
      u_if.wait_n = 1'b1;

      // Read addr 0; write reqs during STROBE (c4) and DONE (c7) are dropped,
      // the one right after ack (c8) is accepted and acks at c15
      u_if.req = 1'b1; u_if.we = 1'b0; u_if.addr = 2'd0;
      tick();
      for (int c = 1; c <= 16; c++) begin
         if (c == 4 || c == 7 || c == 8) begin
            u_if.req = 1'b1; u_if.we = 1'b1; u_if.addr = 2'd3;
         end else begin
            u_if.req = 1'b0; u_if.we = 1'b0; u_if.addr = 2'd0;
         end
         check($sformatf("b2b_A_c%0d", c),    u_if.A, 0);
         check($sformatf("b2b_B_c%0d", c),    u_if.B, (c >= 9) ? 3 : 1);
         check($sformatf("b2b_G1n_c%0d", c),  u_if.G1n, (c >= 3 && c <= 5) ? 0 : 1);
         check($sformatf("b2b_G2n_c%0d", c),  u_if.G2n, (c >= 11 && c <= 13) ? 0 : 1);
         check($sformatf("b2b_ack_c%0d", c),  u_if.ack, (c == 7 || c == 15) ? 1 : 0);
         check($sformatf("b2b_busy_c%0d", c), u_if.busy, (c == 8 || c == 16) ? 0 : 1);
         tick();
      end
      u_if.req = 1'b0;

      // Reset during STROBE of a read to addr 3
      u_if.req = 1'b1; u_if.we = 1'b0; u_if.addr = 2'd3;
      tick();
      u_if.req = 1'b0;
      tick();
      tick();
      check("mid_G1n_before", u_if.G1n, 0);
      #2 rst_n = 1'b0;
      #1;
      check("mid_G1n_async",  u_if.G1n, 1);
      check("mid_G2n_async",  u_if.G2n, 1);
      check("mid_busy_async", u_if.busy, 0);
      check("mid_A_async",    u_if.A, 0);
      check("mid_B_async",    u_if.B, 0);
      check("mid_ack_async",  u_if.ack, 0);
      tick();
      tick();
      rst_n = 1'b1;
      acks = 0;
      busy_seen = 0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (u_if.ack === 1'b1) acks++;
         if (u_if.busy === 1'b1) busy_seen++;
      end
      check("mid_no_ack",  acks, 0);
      check("mid_no_busy", busy_seen, 0);

      // Normal read to addr 1 after the aborted cycle
      u_if.req = 1'b1; u_if.we = 1'b0; u_if.addr = 2'd1;
      tick();
      u_if.req = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         check($sformatf("post_A_c%0d", c),   u_if.A, 1);
         check($sformatf("post_G1n_c%0d", c), u_if.G1n, (c >= 3 && c <= 5) ? 0 : 1);
         check($sformatf("post_ack_c%0d", c), u_if.ack, (c == 7) ? 1 : 0);
         tick();
      end

      // Minimum timing instance: 1/1/1 gives strobe at cycle 2, ack at 4
      u_if_min.req = 1'b1; u_if_min.we = 1'b0; u_if_min.addr = 2'd2;
      tick();
      u_if_min.req = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         check($sformatf("min_rd_A_c%0d", c),    u_if_min.A, 2);
         check($sformatf("min_rd_G1n_c%0d", c),  u_if_min.G1n, (c == 2) ? 0 : 1);
         check($sformatf("min_rd_G2n_c%0d", c),  u_if_min.G2n, 1);
         check($sformatf("min_rd_ack_c%0d", c),  u_if_min.ack, (c == 4) ? 1 : 0);
         check($sformatf("min_rd_busy_c%0d", c), u_if_min.busy, (c <= 4) ? 1 : 0);
         tick();
      end

      u_if_min.req = 1'b1; u_if_min.we = 1'b1; u_if_min.addr = 2'd3;
      tick();
      u_if_min.req = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         check($sformatf("min_wr_B_c%0d", c),   u_if_min.B, 3);
         check($sformatf("min_wr_A_c%0d", c),   u_if_min.A, 2);
         check($sformatf("min_wr_G2n_c%0d", c), u_if_min.G2n, (c == 2) ? 0 : 1);
         check($sformatf("min_wr_G1n_c%0d", c), u_if_min.G1n, 1);
         check($sformatf("min_wr_ack_c%0d", c), u_if_min.ack, (c == 4) ? 1 : 0);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
